// File: rtl/vfd_pkg.sv
// Shared types and helpers for the VFD frequency ramp controller.
package vfd_pkg;
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN, HOLD} state_t;

  localparam int NUM_LEVELS = 10;
  localparam int SEL_W      = 10;
  localparam int LVL_W      = 4;

  // Level 0 maps to 1 so the mux never lands on the top tap while stopped.
  function automatic logic [SEL_W-1:0] lvl2sel(input logic [LVL_W-1:0] lvl);
    logic [SEL_W:0] t;
    t = (lvl == '0) ? (SEL_W+1)'(2) : ((SEL_W+1)'(1) << lvl);
    return SEL_W'(t - (SEL_W+1)'(1));
  endfunction

  function automatic logic [LVL_W-1:0] clamp_tgt(input logic [LVL_W-1:0] t);
    if (t == '0) return LVL_W'(1);
    else if (t > LVL_W'(NUM_LEVELS)) return LVL_W'(NUM_LEVELS);
    else return t;
  endfunction
endpackage

// File: rtl/freq_ramp_ctrl_if.sv
// Control/status bundle between the drive supervisor and the ramp controller.
interface freq_ramp_ctrl_if;
  logic                      run;
  logic                      estop;
  logic [3:0]                target;
  logic [vfd_pkg::SEL_W-1:0] sel;
  logic [3:0]                level;
  logic                      run_en;
  logic                      at_speed;

  modport master (output run, estop, target, input sel, level, run_en, at_speed);
  modport slave  (input run, estop, target, output sel, level, run_en, at_speed);
endinterface

// File: rtl/dwell_timer.sv
// Dwell counter: fires a one-cycle step after DWELL counted cycles.
module dwell_timer #(
  parameter int DWELL = 50000000,
  parameter int DW    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic clear,
  input  logic hold,
  output logic step
);
  logic [DW-1:0] cnt;

  assign step = count && !hold && (cnt == DW'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (clear || hold || step) cnt <= '0;
    else if (count)                 cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/freq_ramp_ctrl.sv
// Speed-level ramp FSM driving a thermometer-coded frequency mux select.
module freq_ramp_ctrl
  import vfd_pkg::*;
#(
  parameter int DWELL = 50000000,
  parameter int DW    = 26
) (
  input logic             clk,
  input logic             rst,
  freq_ramp_ctrl_if.slave bus
);
  state_t           state, nxt_state;
  logic [LVL_W-1:0] level, nxt_level, tgt_eff, floor_lvl;
  logic             step, tmr_clear;

  assign tgt_eff   = clamp_tgt(bus.target);
  assign floor_lvl = bus.run ? tgt_eff : LVL_W'(1);
  assign tmr_clear = (nxt_state != state) || (nxt_level != level);
  assign bus.level = level;

  dwell_timer #(.DWELL(DWELL), .DW(DW)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .count (state != IDLE),
    .clear (tmr_clear),
    .hold  (state == HOLD),
    .step  (step)
  );

  always_comb begin
    nxt_state = state;
    nxt_level = level;
    if (bus.estop) begin
      nxt_state = IDLE;
      nxt_level = '0;
    end else begin
      case (state)
        IDLE: if (bus.run) begin
          nxt_state = RAMP_UP;
          nxt_level = LVL_W'(1);
        end
        RAMP_UP: begin
          if (!bus.run || tgt_eff < level) nxt_state = RAMP_DN;
          else if (step) begin
            if (level < tgt_eff) nxt_level = level + 1'b1;
            if (nxt_level == tgt_eff) nxt_state = HOLD;
          end
        end
        RAMP_DN: begin
          if (bus.run && tgt_eff > level)       nxt_state = RAMP_UP;
          else if (bus.run && level == floor_lvl) nxt_state = HOLD;
          else if (step) begin
            if (level > floor_lvl) begin
              nxt_level = level - 1'b1;
              if (bus.run && nxt_level == floor_lvl) nxt_state = HOLD;
            end else begin
              // Only reachable with run=0 at level 1: stop.
              nxt_state = IDLE;
              nxt_level = '0;
            end
          end
        end
        HOLD: begin
          if (!bus.run || tgt_eff < level) nxt_state = RAMP_DN;
          else if (tgt_eff > level)        nxt_state = RAMP_UP;
        end
        default: begin
          nxt_state = IDLE;
          nxt_level = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      level        <= '0;
      bus.sel      <= SEL_W'(1);
      bus.run_en   <= 1'b0;
      bus.at_speed <= 1'b0;
    end else begin
      state        <= nxt_state;
      level        <= nxt_level;
      bus.sel      <= lvl2sel(nxt_level);
      bus.run_en   <= (nxt_state != IDLE);
      bus.at_speed <= (nxt_state == HOLD);
    end
  end
endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Table-driven bench for freq_ramp_ctrl with DWELL=4; expectations queued at drive time.
module tb_freq_ramp_ctrl;
  localparam int DWELL = 4;
  localparam int DW    = 3;

  typedef struct {
    string      name;
    logic       run;
    logic       estop;
    logic [3:0] target;
    int         ncyc;
    logic [3:0] level;
    logic [9:0] sel;
    logic       run_en;
    logic       at_speed;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  freq_ramp_ctrl_if bus();

  freq_ramp_ctrl #(.DWELL(DWELL), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic r, input logic e,
                              input logic [3:0] t, input int n, input logic [3:0] l,
                              input logic [9:0] s, input logic re, input logic as);
    vec_t v;
    v.name = nm; v.run = r; v.estop = e; v.target = t; v.ncyc = n;
    v.level = l; v.sel = s; v.run_en = re; v.at_speed = as;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [3:0] l, input logic [9:0] s,
                     input logic re, input logic as);
    total++;
    if ({bus.level, bus.sel, bus.run_en, bus.at_speed} !== {l, s, re, as}) begin
      bad++;
      $display("FAIL %s: got level=%0d sel=%0d run_en=%0b at_speed=%0b, want level=%0d sel=%0d run_en=%0b at_speed=%0b",
               nm, bus.level, bus.sel, bus.run_en, bus.at_speed, l, s, re, as);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    bus.run = v.run; bus.estop = v.estop; bus.target = v.target;
    sb.push_back(v);
    repeat (v.ncyc) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      cmp(e.name, e.level, e.sel, e.run_en, e.at_speed);
    end
  endtask

  initial begin
    // ramp up to 3, hold, ramp down to stop
    tbl_a.push_back(mk("idle_no_run", 0, 0, 3,  2, 0, 1,    0, 0));
    tbl_a.push_back(mk("up_lvl1",     1, 0, 3,  1, 1, 1,    1, 0));
    tbl_a.push_back(mk("up_lvl1_c4",  1, 0, 3,  3, 1, 1,    1, 0));
    tbl_a.push_back(mk("up_lvl2",     1, 0, 3,  1, 2, 3,    1, 0));
    tbl_a.push_back(mk("up_lvl3",     1, 0, 3,  4, 3, 7,    1, 1));
    tbl_a.push_back(mk("hold3",       1, 0, 3,  3, 3, 7,    1, 1));
    tbl_a.push_back(mk("dn_enter",    0, 0, 3,  1, 3, 7,    1, 0));
    tbl_a.push_back(mk("dn_lvl3_c3",  0, 0, 3,  3, 3, 7,    1, 0));
    tbl_a.push_back(mk("dn_lvl2",     0, 0, 3,  1, 2, 3,    1, 0));
    tbl_a.push_back(mk("dn_lvl1",     0, 0, 3,  4, 1, 1,    1, 0));
    tbl_a.push_back(mk("dn_idle",     0, 0, 3,  4, 0, 1,    0, 0));
    tbl_a.push_back(mk("idle_stay",   0, 0, 3,  2, 0, 1,    0, 0));
    // retarget 5 -> 2 -> 0 (acts as 1)
    tbl_a.push_back(mk("rt_lvl1",     1, 0, 5,  1, 1, 1,    1, 0));
    tbl_a.push_back(mk("rt_hold5",    1, 0, 5, 16, 5, 31,   1, 1));
    tbl_a.push_back(mk("rt2_enter",   1, 0, 2,  1, 5, 31,   1, 0));
    tbl_a.push_back(mk("rt2_c3",      1, 0, 2,  3, 5, 31,   1, 0));
    tbl_a.push_back(mk("rt2_lvl4",    1, 0, 2,  1, 4, 15,   1, 0));
    tbl_a.push_back(mk("rt2_lvl3",    1, 0, 2,  4, 3, 7,    1, 0));
    tbl_a.push_back(mk("rt2_hold2",   1, 0, 2,  4, 2, 3,    1, 1));
    tbl_a.push_back(mk("rt0_enter",   1, 0, 0,  1, 2, 3,    1, 0));
    tbl_a.push_back(mk("rt0_hold1",   1, 0, 0,  4, 1, 1,    1, 1));
    tbl_a.push_back(mk("rt0_stay",    1, 0, 0,  3, 1, 1,    1, 1));
    // clamp 15 -> 10
    tbl_a.push_back(mk("cl_enter",    1, 0, 15, 1, 1, 1,    1, 0));
    tbl_a.push_back(mk("cl_lvl2",     1, 0, 15, 4, 2, 3,    1, 0));
    tbl_a.push_back(mk("cl_lvl10",    1, 0, 15, 32, 10, 1023, 1, 1));
    tbl_a.push_back(mk("cl_top_stay", 1, 0, 15, 8, 10, 1023, 1, 1));
    // emergency stop
    tbl_a.push_back(mk("es_from_top", 1, 1, 15, 1, 0, 1,    0, 0));
    tbl_a.push_back(mk("es_rel_lvl1", 1, 0, 8,  1, 1, 1,    1, 0));
    tbl_a.push_back(mk("es_lvl6",     1, 0, 8, 20, 6, 63,   1, 0));
    tbl_a.push_back(mk("es_mid_ramp", 1, 1, 8,  1, 0, 1,    0, 0));
    tbl_a.push_back(mk("es_held",     1, 1, 8,  5, 0, 1,    0, 0));
    tbl_a.push_back(mk("es_restart",  1, 0, 8,  1, 1, 1,    1, 0));
    tbl_a.push_back(mk("es_lvl4",     1, 0, 8, 12, 4, 15,   1, 0));
    // after reset restart: immediate RAMP_UP->RAMP_DN and RAMP_DN->RAMP_UP
    tbl_b.push_back(mk("ud_enter",    0, 0, 8,  1, 1, 1,    1, 0));
    tbl_b.push_back(mk("ud_c3",       0, 0, 8,  3, 1, 1,    1, 0));
    tbl_b.push_back(mk("ud_idle",     0, 0, 8,  1, 0, 1,    0, 0));
    tbl_b.push_back(mk("du_lvl1",     1, 0, 4,  1, 1, 1,    1, 0));
    tbl_b.push_back(mk("du_lvl2",     1, 0, 4,  4, 2, 3,    1, 0));
    tbl_b.push_back(mk("du_dn",       0, 0, 4,  1, 2, 3,    1, 0));
    tbl_b.push_back(mk("du_back_up",  1, 0, 4,  1, 2, 3,    1, 0));
    tbl_b.push_back(mk("du_c3",       1, 0, 4,  3, 2, 3,    1, 0));
    tbl_b.push_back(mk("du_lvl3",     1, 0, 4,  1, 3, 7,    1, 0));

    rst = 1'b1; bus.run = 1'b0; bus.estop = 1'b0; bus.target = 4'd0;
    #2;
    cmp("reset_state", 0, 1, 0, 0);
    #10 rst = 1'b0;

    foreach (tbl_a[i]) apply(tbl_a[i]);

    // asynchronous reset mid-ramp at level 4
    #2 rst = 1'b1;
    #1 cmp("rst_async", 0, 1, 0, 0);
    bus.run = 1'b1; bus.target = 4'd8;
    @(posedge clk); #1;
    cmp("rst_held", 0, 1, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("rst_restart", 1, 1, 1, 0);

    foreach (tbl_b[i]) apply(tbl_b[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
